// File: rtl/mem_ctrl_pkg.sv
// Shared widths, IO address decode and request types for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int MEM_ADD_W = 32;
    localparam int MEM_DAT_W = 8;
    localparam int REG_DAT_W = 32;
    localparam int LS_BYTES  = REG_DAT_W / MEM_DAT_W;

    localparam int         IO_SEL_HI  = 17;
    localparam int         IO_SEL_LO  = 16;
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    typedef enum logic {
        GRANT_IC = 1'b0,
        GRANT_LS = 1'b1
    } grant_e;

    typedef struct packed {
        logic                 wr;
        logic [1:0]           sz;
        logic [MEM_ADD_W-1:0] add;
        logic [REG_DAT_W-1:0] dat;
    } ls_req_t;

    function automatic logic is_io(input logic [MEM_ADD_W-1:0] add);
        return add[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL;
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Pending-request latches for the IC and LSB clients plus the round-robin grant.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 idle,
    input  logic                 ic_pulse,
    input  logic [MEM_ADD_W-1:0] ic_pulse_add,
    input  logic                 ls_pulse,
    input  logic                 ls_pulse_wr,
    input  logic [1:0]           ls_pulse_sz,
    input  logic [MEM_ADD_W-1:0] ls_pulse_add,
    input  logic [REG_DAT_W-1:0] ls_pulse_dat,
    output logic                 grant_ic,
    output logic                 grant_ls,
    output logic [MEM_ADD_W-1:0] sel_ic_add,
    output logic                 sel_ls_wr,
    output logic [1:0]           sel_ls_sz,
    output logic [MEM_ADD_W-1:0] sel_ls_add,
    output logic [REG_DAT_W-1:0] sel_ls_dat
);

    logic                 ic_pend_reg, ic_pend_next;
    logic [MEM_ADD_W-1:0] ic_add_reg,  ic_add_next;
    logic                 ls_pend_reg, ls_pend_next;
    ls_req_t              ls_reg,      ls_next;
    grant_e               last_reg,    last_next;

    ls_req_t ls_view;
    logic    ic_want;
    logic    ls_want;

    // A pulse arriving this cycle is visible immediately so an idle controller grants it at once.
    always_comb begin
        ls_view    = ls_pulse ? {ls_pulse_wr, ls_pulse_sz, ls_pulse_add, ls_pulse_dat} : ls_reg;
        sel_ic_add = ic_pulse ? ic_pulse_add : ic_add_reg;
        sel_ls_wr  = ls_view.wr;
        sel_ls_sz  = ls_view.sz;
        sel_ls_add = ls_view.add;
        sel_ls_dat = ls_view.dat;

        ic_want  = (ic_pulse | ic_pend_reg) & ~clr;
        ls_want  = (ls_pulse | ls_pend_reg) & ~(clr & ~ls_view.wr);
        grant_ic = en & idle & ic_want & (~ls_want | (last_reg == GRANT_LS));
        grant_ls = en & idle & ls_want & ~grant_ic;

        ic_pend_next = ic_want & ~grant_ic;
        ls_pend_next = ls_want & ~grant_ls;
        ic_add_next  = sel_ic_add;
        ls_next      = ls_view;
        last_next    = grant_ic ? GRANT_IC : (grant_ls ? GRANT_LS : last_reg);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ic_pend_reg <= 1'b0;
            ic_add_reg  <= '0;
            ls_pend_reg <= 1'b0;
            ls_reg      <= '0;
            last_reg    <= GRANT_LS;
        end else if (en) begin
            ic_pend_reg <= ic_pend_next;
            ic_add_reg  <= ic_add_next;
            ls_pend_reg <= ls_pend_next;
            ls_reg      <= ls_next;
            last_reg    <= last_next;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM sequencer serving IC byte reads and LSB 1/2/4-byte loads and stores.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 iClr,
    input  logic                 iIC_En,
    input  logic [MEM_ADD_W-1:0] iIC_Add,
    output logic                 oIC_En,
    output logic [MEM_DAT_W-1:0] oIC_Dat,
    input  logic                 iLS_En,
    input  logic                 iLS_Wr,
    input  logic [1:0]           iLS_Sz,
    input  logic [MEM_ADD_W-1:0] iLS_Add,
    input  logic [REG_DAT_W-1:0] iLS_Dat,
    output logic                 oLS_En,
    output logic [REG_DAT_W-1:0] oLS_Dat,
    input  logic                 iRAM_Full,
    input  logic [MEM_DAT_W-1:0] iRAM_Dat,
    output logic                 oRAM_Wr,
    output logic [MEM_ADD_W-1:0] oRAM_Add,
    output logic [MEM_DAT_W-1:0] oRAM_Dat
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IC_ADDR = 3'd1,
        IC_DATA = 3'd2,
        LS_RUN  = 3'd3,
        LS_TAIL = 3'd4
    } state_e;

    state_e               state_reg,   state_next;
    logic [MEM_ADD_W-1:0] act_add_reg, act_add_next;
    logic                 act_wr_reg,  act_wr_next;
    logic [1:0]           act_sz_reg,  act_sz_next;
    logic [REG_DAT_W-1:0] act_dat_reg, act_dat_next;
    logic [2:0]           idx_reg,     idx_next;
    logic [REG_DAT_W-1:0] ld_dat_reg,  ld_dat_next;

    logic                 grant_ic, grant_ls;
    logic [MEM_ADD_W-1:0] sel_ic_add, sel_ls_add;
    logic                 sel_ls_wr;
    logic [1:0]           sel_ls_sz;
    logic [REG_DAT_W-1:0] sel_ls_dat;

    logic [MEM_ADD_W-1:0] cur_add;
    logic                 is_load;
    logic                 last_idx;
    logic                 io_stall;
    logic [REG_DAT_W-1:0] ld_cap;
    logic [REG_DAT_W-1:0] ld_merge;
    logic [MEM_DAT_W-1:0] lane_dat [LS_BYTES];

    mem_ctrl_arb u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr          (iClr),
        .idle         (state_reg == IDLE),
        .ic_pulse     (iIC_En),
        .ic_pulse_add (iIC_Add),
        .ls_pulse     (iLS_En),
        .ls_pulse_wr  (iLS_Wr),
        .ls_pulse_sz  (iLS_Sz),
        .ls_pulse_add (iLS_Add),
        .ls_pulse_dat (iLS_Dat),
        .grant_ic     (grant_ic),
        .grant_ls     (grant_ls),
        .sel_ic_add   (sel_ic_add),
        .sel_ls_wr    (sel_ls_wr),
        .sel_ls_sz    (sel_ls_sz),
        .sel_ls_add   (sel_ls_add),
        .sel_ls_dat   (sel_ls_dat)
    );

    assign cur_add  = act_add_reg + MEM_ADD_W'(idx_reg);
    assign is_load  = ~act_wr_reg;
    assign last_idx = (idx_reg == {1'b0, act_sz_reg});
    assign io_stall = (state_reg == LS_RUN) & act_wr_reg & is_io(cur_add) & iRAM_Full;

    // Read data lags the address by one cycle, so index i lands byte i-1; the tail lands byte sz.
    genvar gi;
    generate
        for (gi = 0; gi < LS_BYTES; gi++) begin : g_lane
            assign ld_cap[gi*MEM_DAT_W +: MEM_DAT_W]   = (idx_reg == 3'(gi + 1)) ?
                iRAM_Dat : ld_dat_reg[gi*MEM_DAT_W +: MEM_DAT_W];
            assign ld_merge[gi*MEM_DAT_W +: MEM_DAT_W] = (act_sz_reg == 2'(gi)) ?
                iRAM_Dat : ld_dat_reg[gi*MEM_DAT_W +: MEM_DAT_W];
            assign lane_dat[gi] = act_dat_reg[gi*MEM_DAT_W +: MEM_DAT_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            act_add_reg <= '0;
            act_wr_reg  <= 1'b0;
            act_sz_reg  <= '0;
            act_dat_reg <= '0;
            idx_reg     <= '0;
            ld_dat_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            act_add_reg <= act_add_next;
            act_wr_reg  <= act_wr_next;
            act_sz_reg  <= act_sz_next;
            act_dat_reg <= act_dat_next;
            idx_reg     <= idx_next;
            ld_dat_reg  <= ld_dat_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        act_add_next = act_add_reg;
        act_wr_next  = act_wr_reg;
        act_sz_next  = act_sz_reg;
        act_dat_next = act_dat_reg;
        idx_next     = idx_reg;
        ld_dat_next  = ld_dat_reg;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (grant_ic) begin
                        state_next   = IC_ADDR;
                        act_add_next = sel_ic_add;
                    end else if (grant_ls) begin
                        state_next   = LS_RUN;
                        act_add_next = sel_ls_add;
                        act_wr_next  = sel_ls_wr;
                        act_sz_next  = sel_ls_sz;
                        act_dat_next = sel_ls_dat;
                        idx_next     = '0;
                        if (!sel_ls_wr) begin
                            ld_dat_next = '0;
                        end
                    end
                end
                IC_ADDR: state_next = iClr ? IDLE : IC_DATA;
                IC_DATA: state_next = IDLE;
                LS_RUN: begin
                    if (is_load && iClr) begin
                        state_next = IDLE;
                    end else if (!io_stall) begin
                        if (is_load) begin
                            ld_dat_next = ld_cap;
                        end
                        if (last_idx) begin
                            state_next = LS_TAIL;
                        end else begin
                            idx_next = idx_reg + 3'd1;
                        end
                    end
                end
                LS_TAIL: begin
                    if (is_load && !iClr) begin
                        ld_dat_next = ld_merge;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        oRAM_Wr  = 1'b0;
        oRAM_Add = '0;
        oRAM_Dat = '0;
        oIC_En   = 1'b0;
        oIC_Dat  = '0;
        oLS_En   = 1'b0;
        oLS_Dat  = ld_dat_reg;
        case (state_reg)
            IC_ADDR: oRAM_Add = act_add_reg;
            IC_DATA: begin
                oIC_Dat = iRAM_Dat;
                oIC_En  = en & ~iClr;
            end
            LS_RUN: begin
                oRAM_Add = cur_add;
                if (act_wr_reg) begin
                    oRAM_Dat = lane_dat[idx_reg[1:0]];
                    oRAM_Wr  = en & ~io_stall;
                end
            end
            LS_TAIL: begin
                oLS_En = en & ~(is_load & iClr);
                if (is_load) begin
                    oLS_Dat = ld_merge;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte ROM model, response and write scoreboards checked every cycle.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n, en, iClr;
    logic                 iIC_En;
    logic [MEM_ADD_W-1:0] iIC_Add;
    logic                 oIC_En;
    logic [MEM_DAT_W-1:0] oIC_Dat;
    logic                 iLS_En, iLS_Wr;
    logic [1:0]           iLS_Sz;
    logic [MEM_ADD_W-1:0] iLS_Add;
    logic [REG_DAT_W-1:0] iLS_Dat;
    logic                 oLS_En;
    logic [REG_DAT_W-1:0] oLS_Dat;
    logic                 iRAM_Full;
    logic [MEM_DAT_W-1:0] iRAM_Dat;
    logic                 oRAM_Wr;
    logic [MEM_ADD_W-1:0] oRAM_Add;
    logic [MEM_DAT_W-1:0] oRAM_Dat;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .iClr      (iClr),
        .iIC_En    (iIC_En),
        .iIC_Add   (iIC_Add),
        .oIC_En    (oIC_En),
        .oIC_Dat   (oIC_Dat),
        .iLS_En    (iLS_En),
        .iLS_Wr    (iLS_Wr),
        .iLS_Sz    (iLS_Sz),
        .iLS_Add   (iLS_Add),
        .iLS_Dat   (iLS_Dat),
        .oLS_En    (oLS_En),
        .oLS_Dat   (oLS_Dat),
        .iRAM_Full (iRAM_Full),
        .iRAM_Dat  (iRAM_Dat),
        .oRAM_Wr   (oRAM_Wr),
        .oRAM_Add  (oRAM_Add),
        .oRAM_Dat  (oRAM_Dat)
    );

    // Read-only byte memory: data for the address seen at an edge is valid the following cycle.
    logic [7:0] mem [0:4095];
    always @(posedge clk) iRAM_Dat <= mem[oRAM_Add[11:0]];

    typedef struct { bit is_ls; bit chk_dat; logic [31:0] dat; int cyc; } rsp_t;
    typedef struct { logic [31:0] add; logic [7:0] dat; int cyc; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        rsp_t r;
        wr_t  w;
        @(negedge clk);
        ncyc++;
        if (oIC_En === 1'b1 || oLS_En === 1'b1) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 32'({oIC_En, oLS_En}), 32'd0);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_kind", 32'(oLS_En), 32'(r.is_ls));
                if (r.chk_dat) check("rsp_dat", r.is_ls ? oLS_Dat : 32'(oIC_Dat), r.dat);
                check("rsp_cycle", ncyc, r.cyc);
                $display("cycle %0d: %s response data %h", ncyc, r.is_ls ? "LS" : "IC",
                         r.is_ls ? oLS_Dat : 32'(oIC_Dat));
            end
        end
        if (oRAM_Wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr", oRAM_Add, 32'hFFFF_FFFF);
            end else begin
                w = wr_q.pop_front();
                check("wr_add", oRAM_Add, w.add);
                check("wr_dat", 32'(oRAM_Dat), 32'(w.dat));
                check("wr_cycle", ncyc, w.cyc);
                $display("cycle %0d: RAM write %h <= %h", ncyc, oRAM_Add, oRAM_Dat);
            end
        end
    endtask

    task automatic exp_rsp(input bit is_ls, input bit chk, input logic [31:0] dat, input int dly);
        rsp_q.push_back('{is_ls, chk, dat, ncyc + dly});
    endtask

    task automatic exp_wr(input logic [31:0] add, input logic [7:0] dat, input int dly);
        wr_q.push_back('{add, dat, ncyc + dly});
    endtask

    task automatic issue(input bit ic, input logic [31:0] ic_add, input bit ls, input bit wr,
                         input logic [1:0] sz, input logic [31:0] add, input logic [31:0] dat);
        iIC_En  = ic;
        iIC_Add = ic_add;
        iLS_En  = ls;
        iLS_Wr  = wr;
        iLS_Sz  = sz;
        iLS_Add = add;
        iLS_Dat = dat;
        step();
        iIC_En = 1'b0;
        iLS_En = 1'b0;
    endtask

    task automatic ic_read(input logic [31:0] add);
        issue(1'b1, add, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    task automatic ls_op(input bit wr, input logic [1:0] sz, input logic [31:0] add, input logic [31:0] dat);
        issue(1'b0, 32'd0, 1'b1, wr, sz, add, dat);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < max) begin
            step();
            n++;
        end
        check("drain_pending", 32'(rsp_q.size() + wr_q.size()), 32'd0);
        rsp_q.delete();
        wr_q.delete();
        step();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ic_en"},   32'(oIC_En),   32'd0);
        check({tag, "_ic_dat"},  32'(oIC_Dat),  32'd0);
        check({tag, "_ls_en"},   32'(oLS_En),   32'd0);
        check({tag, "_ls_dat"},  oLS_Dat,       32'd0);
        check({tag, "_ram_wr"},  32'(oRAM_Wr),  32'd0);
        check({tag, "_ram_add"}, oRAM_Add,      32'd0);
        check({tag, "_ram_dat"}, 32'(oRAM_Dat), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem['h100] = 8'hAB;
        mem['h200] = 8'h11;
        mem['h201] = 8'h22;
        mem['h202] = 8'h33;
        mem['h203] = 8'h44;
        mem['h210] = 8'hFF;

        rst_n = 1'b0; en = 1'b1; iClr = 1'b0; iRAM_Full = 1'b0;
        iIC_En = 1'b0; iIC_Add = '0;
        iLS_En = 1'b0; iLS_Wr = 1'b0; iLS_Sz = '0; iLS_Add = '0; iLS_Dat = '0;
        repeat (3) step();
        check_quiet("reset");
        rst_n = 1'b1;
        step();

        // IC byte read
        exp_rsp(1'b0, 1'b1, 32'hAB, 2);
        ic_read(32'h100);
        check("ic_addr_c1", oRAM_Add, 32'h100);
        drain(10);

        // 4-byte load, then 1-byte load must zero-extend
        exp_rsp(1'b1, 1'b1, 32'h44332211, 5);
        ls_op(1'b0, 2'd3, 32'h200, 32'd0);
        check("ld_addr_c1", oRAM_Add, 32'h200);
        step();
        check("ld_addr_c2", oRAM_Add, 32'h201);
        drain(10);
        exp_rsp(1'b1, 1'b1, 32'h000000FF, 2);
        ls_op(1'b0, 2'd0, 32'h210, 32'd0);
        drain(10);

        // 2-byte store
        exp_wr(32'h300, 8'hEF, 1);
        exp_wr(32'h301, 8'hBE, 2);
        exp_rsp(1'b1, 1'b0, 32'd0, 3);
        ls_op(1'b1, 2'd1, 32'h300, 32'h0000BEEF);
        drain(10);

        // Full only stalls IO-space stores
        iRAM_Full = 1'b1;
        exp_wr(32'h304, 8'h77, 1);
        exp_rsp(1'b1, 1'b0, 32'd0, 2);
        ls_op(1'b1, 2'd0, 32'h304, 32'h77);
        drain(10);
        exp_wr(32'h30000, 8'h5A, 4);
        exp_rsp(1'b1, 1'b0, 32'd0, 5);
        ls_op(1'b1, 2'd0, 32'h30000, 32'h5A);
        step();
        step();
        @(posedge clk);
        #1 iRAM_Full = 1'b0;
        drain(10);

        // Round robin: IC wins the first pair, the pair latched meanwhile goes LS first
        exp_rsp(1'b0, 1'b1, 32'hAB, 2);
        issue(1'b1, 32'h100, 1'b1, 1'b0, 2'd3, 32'h200, 32'd0);
        exp_rsp(1'b1, 1'b1, 32'h000000FF, 4);
        exp_rsp(1'b0, 1'b1, 32'h11, 7);
        issue(1'b1, 32'h200, 1'b1, 1'b0, 2'd0, 32'h210, 32'd0);
        drain(20);

        // en low freezes an IC read for two cycles
        exp_rsp(1'b0, 1'b1, 32'h22, 4);
        ic_read(32'h201);
        en = 1'b0;
        step();
        check("frozen_addr", oRAM_Add, 32'h201);
        step();
        en = 1'b1;
        drain(10);

        // Flush mid load also drops an IC request pending behind it
        ls_op(1'b0, 2'd3, 32'h200, 32'd0);
        ic_read(32'h100);
        iClr = 1'b1;
        step();
        iClr = 1'b0;
        repeat (6) step();
        exp_rsp(1'b0, 1'b1, 32'hAB, 2);
        ic_read(32'h100);
        drain(10);

        // Reset in the middle of a 4-byte store
        exp_wr(32'h400, 8'hEF, 1);
        exp_wr(32'h401, 8'hBE, 2);
        ls_op(1'b1, 2'd3, 32'h400, 32'hDEADBEEF);
        step();
        rst_n = 1'b0;
        step();
        check_quiet("mid_reset");
        check("store_wr_seen", 32'(wr_q.size()), 32'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // After reset a simultaneous pair serves IC first, then LS
        exp_rsp(1'b0, 1'b1, 32'hAB, 2);
        exp_rsp(1'b1, 1'b1, 32'h00000011, 5);
        issue(1'b1, 32'h100, 1'b1, 1'b0, 2'd0, 32'h200, 32'd0);
        drain(20);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
